// File: rtl/mem_writeback_unit.sv
// mem_writeback_unit: memory-access and writeback stage behind execute.
// Takes one ExecInst at a time. LOAD/STORE go out over a valid/ready
// request bus and wait for a response (with an optional timeout). Load data
// is aligned and extended, then the register-file write and commit are issued.
// Optional build macro MISALIGN_TRAP_EN: traps misaligned LW/LH/LHU/SH
// without a memory access, and adds the output port `misaligned`.
module mem_writeback_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  iType,
    input  logic [2:0]  memFunc,
    input  logic        werf,
    input  logic [4:0]  rdIndex,
    input  logic [31:0] data,
    input  logic [31:0] addr,
    input  logic [31:0] nextPc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        rf_we,
    output logic [4:0]  rf_windex,
    output logic [31:0] rf_wdata,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic        illegal,
`ifdef MISALIGN_TRAP_EN
    output logic        bus_err,
    output logic        misaligned
`else
    output logic        bus_err
`endif
);
    localparam logic [3:0] T_LOAD  = 4'd6;
    localparam logic [3:0] T_STORE = 4'd7;
    localparam logic [3:0] T_UNSUP = 4'd9;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       itype_q, itype_d;
    logic [2:0]       func_q, func_d;
    logic             werf_q, werf_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      npc_q, npc_d;
    logic [31:0]      resp_q, resp_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             misal_q, misal_d;

    // Unsupported types (9 and above) and memFunc codes outside the load/store sets.
    function automatic logic func_illegal(input logic [3:0] t, input logic [2:0] f);
        if (t == T_LOAD)  return !(f == 3'b000 || f == 3'b001 || f == 3'b010 ||
                                   f == 3'b100 || f == 3'b101);
        if (t == T_STORE) return (f > 3'b010);
        return (t >= T_UNSUP);
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] store_wdata(input logic [2:0] f, input logic [31:0] d);
        case (f)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [2:0] f, input logic [1:0] a);
        case (f)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Picks the addressed lane out of the response word and extends it.
    function automatic logic [31:0] load_align(input logic [2:0] f, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [3:0] t, input logic [2:0] f,
                                           input logic [1:0] a);
        if (t == T_LOAD && f == 3'b010)                      return (a != 2'b00);
        if (t == T_LOAD && (f == 3'b001 || f == 3'b101))     return a[0];
        if (t == T_STORE && f == 3'b001)                     return a[0];
        return 1'b0;
    endfunction
`endif

    assign in_ready = (state_q == S_IDLE) && !rst;

    // Next-state logic: accept/latch, request handshake, response wait with timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        itype_d   = itype_q;
        func_d    = func_q;
        werf_d    = werf_q;
        rd_d      = rd_q;
        data_d    = data_q;
        addr_d    = addr_q;
        npc_d     = npc_q;
        resp_d    = resp_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        misal_d   = misal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    itype_d   = iType;
                    func_d    = memFunc;
                    werf_d    = werf;
                    rd_d      = rdIndex;
                    data_d    = data;
                    addr_d    = addr;
                    npc_d     = nextPc;
                    illegal_d = func_illegal(iType, memFunc);
                    bus_err_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    misal_d   = is_misaligned(iType, memFunc, addr[1:0]);
`else
                    misal_d   = 1'b0;
`endif
                    if ((iType == T_LOAD || iType == T_STORE) && !illegal_d && !misal_d)
                        state_d = S_REQ;
                    else
                        state_d = S_WB;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_resp_valid) begin
                    resp_d  = mem_resp_data;
                    state_d = S_WB;
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_WB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: reset drops any in-flight transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched instruction and response; only observed after a fresh accept.
    always_ff @(posedge clk) begin
        itype_q   <= itype_d;
        func_q    <= func_d;
        werf_q    <= werf_d;
        rd_q      <= rd_d;
        data_q    <= data_d;
        addr_q    <= addr_d;
        npc_q     <= npc_d;
        resp_q    <= resp_d;
        illegal_q <= illegal_d;
        bus_err_q <= bus_err_d;
        misal_q   <= misal_d;
    end

    // Outputs decoded from state; everything is zero outside REQ and WB.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = 32'd0;
        mem_req_wdata = 32'd0;
        mem_req_wstrb = 4'd0;
        rf_we         = 1'b0;
        rf_windex     = 5'd0;
        rf_wdata      = 32'd0;
        commit_valid  = 1'b0;
        commit_pc     = 32'd0;
        illegal       = 1'b0;
        bus_err       = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misaligned    = 1'b0;
`endif
        case (state_q)
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {addr_q[31:2], 2'b00};
                if (itype_q == T_STORE) begin
                    mem_req_write = 1'b1;
                    mem_req_wdata = store_wdata(func_q, data_q);
                    mem_req_wstrb = store_wstrb(func_q, addr_q[1:0]);
                end
            end
            S_WB: begin
                commit_valid = 1'b1;
                commit_pc    = npc_q;
                rf_windex    = rd_q;
                rf_wdata     = (itype_q == T_LOAD) ? load_align(func_q, addr_q[1:0], resp_q)
                                                   : data_q;
                rf_we        = werf_q && (rd_q != 5'd0) && !illegal_q && !bus_err_q &&
                               !misal_q && (itype_q != T_STORE);
                illegal      = illegal_q;
                bus_err      = bus_err_q;
`ifdef MISALIGN_TRAP_EN
                misaligned   = misal_q;
`endif
            end
            default: ;
        endcase
    end

endmodule
